// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared types and constants for the execute result stage:
//               flag snapshot, condition codes and result-buffer entries.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // Widths of the arithmetic unit this stage is paired with
    localparam int EX_BITS  = 16;
    localparam int EX_RDW   = 4;

    // Result buffer depth and width of its occupancy counter (0..EX_DEPTH)
    localparam int EX_DEPTH = 2;
    localparam int EX_CNTW  = 2;

    // Flag snapshot, packed MSB-first as {O,C,S,Z}
    typedef struct packed {
        logic o;
        logic c;
        logic s;
        logic z;
    } flags_t;

    // Branch condition codes evaluated against the architectural flags
    typedef enum logic [3:0] {
        COND_AL   = 4'd0,   // always
        COND_EQ   = 4'd1,   // Z
        COND_NE   = 4'd2,   // !Z
        COND_MI   = 4'd3,   // S
        COND_PL   = 4'd4,   // !S
        COND_CS   = 4'd5,   // C
        COND_CC   = 4'd6,   // !C
        COND_VS   = 4'd7,   // O
        COND_VC   = 4'd8,   // !O
        COND_LT   = 4'd9,   // S^O
        COND_GT   = 4'd10,  // !(S^O) && !Z
        COND_LE   = 4'd11,  // Z || (S^O)
        COND_GE   = 4'd12,  // !(S^O)
        COND_NV13 = 4'd13,  // never
        COND_NV14 = 4'd14,  // never
        COND_NV15 = 4'd15   // never
    } cond_e;

    // One buffered result beat
    typedef struct packed {
        logic [EX_BITS-1:0] resu;
        logic [EX_RDW-1:0]  rd;
        flags_t             flags;
    } ex_entry_t;

endpackage
`default_nettype wire

// File: rtl/ex_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ex_skid_fifo
// Description : Two-entry in-order result buffer. Slot 0 is always the head,
//               so the head is a plain register output. Ready and valid are
//               registered from the next-state count, keeping the input side
//               free of any combinational path from the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_skid_fifo
    import ex_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  ex_entry_t          data_i,
    output ex_entry_t          data_o,
    output logic               valid_o,
    output logic               ready_o,
    output logic [EX_CNTW-1:0] count_o
);

    localparam logic [EX_CNTW-1:0] c_FULL_CNT = EX_CNTW'(EX_DEPTH);
    localparam logic [EX_CNTW-1:0] c_ONE      = EX_CNTW'(1);

    ex_entry_t          entry0_q, entry0_d;
    ex_entry_t          entry1_q, entry1_d;
    logic [EX_CNTW-1:0] count_q, count_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;

    logic               w_push;
    logic               w_pop;

    // Requests are qualified by our own registered state so an illegal
    // push-when-full or pop-when-empty can never corrupt the buffer.
    assign w_push = push_i && ready_q;
    assign w_pop  = pop_i && valid_q;

    // Next-state: shift on pop, fill the first free slot on push
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Only reachable with one entry: new beat replaces head
                    entry0_d = data_i;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - c_ONE;
                end
                2'b10: begin
                    if (count_q == '0) begin
                        entry0_d = data_i;
                    end else begin
                        entry1_d = data_i;
                    end
                    count_d = count_q + c_ONE;
                end
                default: begin
                end
            endcase
        end
        valid_d = (count_d != '0);
        ready_d = (count_d != c_FULL_CNT);
    end

    // Buffer storage and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign data_o  = entry0_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_result_stage
// Description : Execute-stage result register behind the 16-bit arithmetic
//               unit. Buffers result beats in a 2-entry skid FIFO, keeps the
//               architectural {O,C,S,Z} flag register and evaluates branch
//               condition codes against it.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int BITS = EX_BITS,   // must equal EX_BITS (entry struct width)
    parameter int RDW  = EX_RDW     // must equal EX_RDW
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_resu,
    input  logic            in_o,
    input  logic            in_c,
    input  logic            in_s,
    input  logic            in_z,
    input  logic [RDW-1:0]  in_rd,
    input  logic            in_wflag,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_resu,
    output logic [RDW-1:0]  out_rd,
    output logic [3:0]      out_flags,

    output logic [3:0]      flags,
    input  logic [3:0]      cond,
    output logic            cond_true
);

    flags_t             flags_q, flags_d;
    flags_t             w_in_flags;
    ex_entry_t          w_in_entry;
    ex_entry_t          w_head;
    logic               w_accept;
    logic [EX_CNTW-1:0] w_count;
    logic               w_s_xor_o;

    assign w_in_flags = '{o: in_o, c: in_c, s: in_s, z: in_z};
    assign w_in_entry = '{resu: in_resu, rd: in_rd, flags: w_in_flags};

    // A beat presented during a flush is dropped entirely, flags included
    assign w_accept = in_valid && in_ready && !flush;

    ex_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid && !flush),
        .pop_i   (out_ready),
        .flush_i (flush),
        .data_i  (w_in_entry),
        .data_o  (w_head),
        .valid_o (out_valid),
        .ready_o (in_ready),
        .count_o (w_count)
    );

    assign out_resu  = w_head.resu;
    assign out_rd    = w_head.rd;
    assign out_flags = w_head.flags;

    // Architectural flags follow accepted beats that request a flag write
    always_comb begin
        flags_d = flags_q;
        if (w_accept && in_wflag) begin
            flags_d = w_in_flags;
        end
    end

    // Flag register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags     = flags_q;
    assign w_s_xor_o = flags_q.s ^ flags_q.o;

    // Branch condition decode on the registered flags
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags_q.z;
            COND_NE: cond_true = !flags_q.z;
            COND_MI: cond_true = flags_q.s;
            COND_PL: cond_true = !flags_q.s;
            COND_CS: cond_true = flags_q.c;
            COND_CC: cond_true = !flags_q.c;
            COND_VS: cond_true = flags_q.o;
            COND_VC: cond_true = !flags_q.o;
            COND_LT: cond_true = w_s_xor_o;
            COND_GT: cond_true = !w_s_xor_o && !flags_q.z;
            COND_LE: cond_true = flags_q.z || w_s_xor_o;
            COND_GE: cond_true = !w_s_xor_o;
            default: cond_true = 1'b0;
        endcase
    end

    // Occupancy is kept for debug visibility only
    logic w_unused;
    assign w_unused = ^w_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_result_stage
// Description : Self-checking bench for ex_result_stage. A queue-based model
//               tracks buffered beats, flags and condition results; directed
//               sequences are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_resu = '0;
    logic        in_o = 1'b0, in_c = 1'b0, in_s = 1'b0, in_z = 1'b0;
    logic [3:0]  in_rd = '0;
    logic        in_wflag = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_resu;
    logic [3:0]  out_rd;
    logic [3:0]  out_flags;
    logic [3:0]  flags;
    logic [3:0]  cond = '0;
    logic        cond_true;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] resu;
        logic [3:0]  rd;
        logic [3:0]  fl;
    } mentry_t;

    mentry_t     mq[$];
    logic [3:0]  mflags = '0;

    always #5 clk = ~clk;

    ex_result_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_resu   (in_resu),
        .in_o      (in_o),
        .in_c      (in_c),
        .in_s      (in_s),
        .in_z      (in_z),
        .in_rd     (in_rd),
        .in_wflag  (in_wflag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_resu  (out_resu),
        .out_rd    (out_rd),
        .out_flags (out_flags),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Condition truth table written from the flag meanings {O,C,S,Z}
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic o, cy, s, z;
        logic lt;
        o = f[3]; cy = f[2]; s = f[1]; z = f[0];
        lt = (s != o);
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return s;
            4'd4:    return !s;
            4'd5:    return cy;
            4'd6:    return !cy;
            4'd7:    return o;
            4'd8:    return !o;
            4'd9:    return lt;
            4'd10:   return !lt && !z;
            4'd11:   return z || lt;
            4'd12:   return !lt;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus: drive, compare at negedge, advance model at posedge
    task automatic step(input bit v, input logic [15:0] r, input logic [3:0] f,
                        input logic [3:0] rd, input bit wf, input bit ordy,
                        input bit fl, input logic [3:0] cc);
        bit      exp_valid, exp_ready, acc, pop;
        mentry_t e;
        in_valid  = v;
        in_resu   = r;
        {in_o, in_c, in_s, in_z} = f;
        in_rd     = rd;
        in_wflag  = wf;
        out_ready = ordy;
        flush     = fl;
        cond      = cc;
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        exp_ready = (mq.size() < 2);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("flags", 32'(flags), 32'(mflags));
        check("cond_true", 32'(cond_true), 32'(ref_cond(mflags, cc)));
        if (exp_valid) begin
            check("out_resu", 32'(out_resu), 32'(mq[0].resu));
            check("out_rd", 32'(out_rd), 32'(mq[0].rd));
            check("out_flags", 32'(out_flags), 32'(mq[0].fl));
        end
        acc = v && exp_ready && !fl;
        pop = exp_valid && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.resu = r; e.rd = rd; e.fl = f;
                mq.push_back(e);
            end
        end
        if (acc && wf) mflags = f;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock
    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_flags", 32'(flags), 32'd0);
        check("arst_out_resu", 32'(out_resu), 32'd0);
        mq.delete();
        mflags = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_resu", 32'(out_resu), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        // Condition sweep on reset flags
        for (int c = 0; c < 16; c++) step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'(c));

        // Single beat: 7FFF with O=1,S=1 to rd 3
        step(1, 16'h7FFF, 4'b1010, 4'd3, 1, 1, 0, 4'd7);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd7);
        check("single_flags", 32'(flags), 32'hA);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd7);

        // Backpressure: third beat is held off until a pop frees a slot
        step(1, 16'h0001, 4'h0, 4'd1, 0, 0, 0, 4'd0);
        step(1, 16'h0002, 4'h0, 4'd2, 0, 0, 0, 4'd0);
        step(1, 16'h0003, 4'h0, 4'd3, 0, 0, 0, 4'd0);
        check("bp_full", 32'(in_ready), 32'd0);
        step(1, 16'h0003, 4'h0, 4'd3, 0, 1, 0, 4'd0);
        step(1, 16'h0003, 4'h0, 4'd3, 0, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd0);

        // Zero result and a non-flag-writing beat
        step(1, 16'h0000, 4'b0001, 4'd5, 1, 1, 0, 4'd1);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd1);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd2);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd11);
        step(1, 16'h1234, 4'b0000, 4'd6, 0, 1, 0, 4'd1);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd1);
        check("wflag0_hold", 32'(flags), 32'h1);

        // Signed comparisons
        step(1, 16'h8000, 4'b0010, 4'd7, 1, 1, 0, 4'd9);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd9);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd12);
        step(1, 16'h8001, 4'b1010, 4'd8, 1, 1, 0, 4'd9);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd9);
        step(0, 16'h0, 4'h0, 4'h0, 0, 1, 0, 4'd10);

        // Flush with two entries and a concurrent flag-writing beat
        step(1, 16'hAAAA, 4'h0, 4'd1, 0, 0, 0, 4'd0);
        step(1, 16'hBBBB, 4'h0, 4'd2, 0, 0, 0, 4'd0);
        step(1, 16'hCCCC, 4'hF, 4'd3, 1, 0, 1, 4'd0);
        step(0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
        check("flush_flags", 32'(flags), 32'hA);

        // Randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            step($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
                 4'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
